mem_bus_arbiter: RTL and testbench

Shares the single memory-unit port between the CPU's instruction-fetch stage (IF) and the data-memory stage (DM, driven by the `mem_read`/`mem_write` decode). It is a registered two-requester arbiter with round-robin tie-breaking. It launches one bus access at a time and returns read data plus a one-cycle acknowledge to the winning requester. It sits between the CPU pipeline and the memory unit.

---
 rtl/mem_bus_arbiter.sv | 102 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory port arbiter (instruction fetch vs. data memory).
// Launches one bus access at a time; a tie goes to the requester that lost the previous grant.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_q,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_q,
  output logic              dm_ack,
  output logic              bus_start,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_q,
  input  logic              bus_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last_grant;  // 0 = IF won last, 1 = DM won last

  logic w_if_eff;
  logic w_dm_eff;
  logic w_grant_if;
  logic w_grant_dm;

  // A requester is masked during its own ack cycle so a held level is not re-granted.
  assign w_if_eff   = if_req & ~if_ack;
  assign w_dm_eff   = dm_req & ~dm_ack;
  assign w_grant_if = w_if_eff & (~w_dm_eff | r_last_grant);
  assign w_grant_dm = w_dm_eff & ~w_grant_if;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      bus_start    <= 1'b0;
      bus_addr     <= '0;
      bus_data     <= '0;
      bus_we       <= 1'b0;
      if_ack       <= 1'b0;
      dm_ack       <= 1'b0;
      if_q         <= '0;
      dm_q         <= '0;
    end else begin
      bus_start <= 1'b0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_if) begin
            r_state      <= BUSY_IF;
            r_last_grant <= 1'b0;
            bus_start    <= 1'b1;
            bus_addr     <= if_addr;
            bus_data     <= '0;
            bus_we       <= 1'b0;
          end else if (w_grant_dm) begin
            r_state      <= BUSY_DM;
            r_last_grant <= 1'b1;
            bus_start    <= 1'b1;
            bus_addr     <= dm_addr;
            bus_data     <= dm_wdata;
            bus_we       <= dm_we;
          end
        end
        BUSY_IF: begin
          if (bus_done) begin
            r_state <= IDLE;
            if_ack  <= 1'b1;
            if_q    <= bus_q;
          end
        end
        BUSY_DM: begin
          if (bus_done) begin
            r_state <= IDLE;
            dm_ack  <= 1'b1;
            if (!bus_we) begin
              dm_q <= bus_q;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 27;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, dm_req, dm_we, bus_done;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, bus_q;
  logic [DW-1:0] if_q, dm_q, bus_data;
  logic [AW-1:0] bus_addr;
  logic          if_ack, dm_ack, bus_start, bus_we;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: who owns the bus and whose turn a tie is, plus the expected outputs.
  int            m_owner;       // 0 = nobody, 1 = fetch, 2 = data
  bit            m_fetch_turn;  // fetch wins the next tie
  logic          e_start, e_we, e_if_ack, e_dm_ack;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data, e_if_q, e_dm_q;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_q(if_q), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_q(dm_q), .dm_ack(dm_ack),
    .bus_start(bus_start), .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we),
    .bus_q(bus_q), .bus_done(bus_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outs();
    check_eq("bus_start", 32'(bus_start), 32'(e_start));
    check_eq("bus_addr",  32'(bus_addr),  32'(e_addr));
    check_eq("bus_data",  bus_data,       e_data);
    check_eq("bus_we",    32'(bus_we),    32'(e_we));
    check_eq("if_ack",    32'(if_ack),    32'(e_if_ack));
    check_eq("dm_ack",    32'(dm_ack),    32'(e_dm_ack));
    check_eq("if_q",      if_q,           e_if_q);
    check_eq("dm_q",      dm_q,           e_dm_q);
  endtask

  task automatic model_reset();
    m_owner = 0; m_fetch_turn = 1'b1;
    e_start = 0; e_we = 0; e_if_ack = 0; e_dm_ack = 0;
    e_addr = '0; e_data = '0; e_if_q = '0; e_dm_q = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit f_want, d_want;
    f_want = if_req && !e_if_ack;
    d_want = dm_req && !e_dm_ack;
    e_start = 0; e_if_ack = 0; e_dm_ack = 0;
    if (m_owner == 0) begin
      if (f_want && (!d_want || m_fetch_turn)) begin
        m_owner = 1; m_fetch_turn = 1'b0;
        e_start = 1; e_addr = if_addr; e_data = '0; e_we = 0;
      end else if (d_want) begin
        m_owner = 2; m_fetch_turn = 1'b1;
        e_start = 1; e_addr = dm_addr; e_data = dm_wdata; e_we = dm_we;
      end
    end else if (bus_done) begin
      if (m_owner == 1) begin
        e_if_ack = 1; e_if_q = bus_q;
      end else begin
        e_dm_ack = 1;
        if (!e_we) e_dm_q = bus_q;
      end
      m_owner = 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outs();
  endtask

  // Asynchronous reset asserted mid-cycle and held over one edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outs();
    @(posedge clk);
    #1;
    check_outs();
    reset = 1'b0;
  endtask

  initial begin
    int n_gr, last_ack, resp_cnt;
    bit prev_start;

    reset = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0; bus_done = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; bus_q = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outs();
    reset = 1'b0;

    // Reset in the middle of a data read, then a late bus_done must not ack.
    dm_req = 1; dm_we = 0; dm_addr = AW'(32'h300);
    tick();
    tick();
    do_reset();
    dm_req = 0;
    bus_done = 1; bus_q = 32'h5555_AAAA;
    tick();
    check_eq("rst_no_ack", 32'(dm_ack), 32'h0);
    bus_done = 0;
    // First tie after reset goes to fetch.
    if_req = 1; if_addr = AW'(32'h010); dm_req = 1; dm_addr = AW'(32'h020);
    tick();
    check_eq("rst_first_tie", 32'(bus_addr), 32'h010);
    dm_req = 0;
    bus_done = 1; bus_q = 32'h0BAD_F00D;
    tick();
    if_req = 0; bus_done = 0;
    tick();

    // Single fetch, bus_done three cycles after bus_start.
    if_req = 1; if_addr = AW'(32'h100);
    tick();
    check_eq("fetch_start", 32'(bus_start), 32'h1);
    check_eq("fetch_we",    32'(bus_we),    32'h0);
    check_eq("fetch_addr",  32'(bus_addr),  32'h100);
    repeat (3) tick();
    bus_done = 1; bus_q = 32'hDEAD_BEEF;
    tick();
    check_eq("fetch_ack", 32'(if_ack), 32'h1);
    check_eq("fetch_q",   if_q,        32'hDEAD_BEEF);
    if_req = 0; bus_done = 0;
    tick();
    check_eq("fetch_ack_pulse", 32'(if_ack), 32'h0);

    // Data write leaves dm_q untouched.
    dm_req = 1; dm_we = 1; dm_addr = AW'(32'h200); dm_wdata = 32'h1234_5678;
    tick();
    check_eq("wr_we",   32'(bus_we), 32'h1);
    check_eq("wr_data", bus_data,    32'h1234_5678);
    bus_done = 1; bus_q = 32'hFFFF_0000;
    tick();
    check_eq("wr_ack", 32'(dm_ack), 32'h1);
    check_eq("wr_q",   dm_q,        32'h0);
    dm_req = 0; dm_we = 0; bus_done = 0;
    tick();

    // Continuous contention: strict alternation, next start one cycle after each ack.
    if_req = 1; if_addr = AW'(32'h111); dm_req = 1; dm_addr = AW'(32'h222); dm_we = 0;
    n_gr = 0; last_ack = 0; prev_start = 0;
    for (int i = 0; i < 40 && n_gr < 4; i++) begin
      tick();
      if (if_ack || dm_ack) last_ack = cyc;
      if (bus_start) begin
        check_eq("cont_order", 32'(bus_addr), (n_gr % 2 == 0) ? 32'h111 : 32'h222);
        if (n_gr > 0) check_eq("cont_gap", 32'(cyc - last_ack), 32'h1);
        n_gr++;
      end
      if (n_gr < 4) begin
        bus_done = prev_start; bus_q = $urandom();
        prev_start = bus_start;
      end
    end
    check_eq("cont_count", 32'(n_gr), 32'h4);
    if_req = 0; dm_req = 0;
    bus_done = 1; bus_q = $urandom();
    tick();
    bus_done = 0;
    tick();

    // Zero-wait bus: done in the start cycle, ack two cycles after request, no relaunch.
    dm_req = 1; dm_we = 0; dm_addr = AW'(32'h033);
    tick();
    bus_done = 1; bus_q = 32'h0000_00AA;
    tick();
    check_eq("zw_ack", 32'(dm_ack), 32'h1);
    check_eq("zw_q",   dm_q,        32'h0000_00AA);
    bus_done = 0;
    tick();
    check_eq("zw_no_relaunch", 32'(bus_start), 32'h0);
    dm_req = 0;
    tick();

    // Stray bus_done while idle, then request fields changed mid-access.
    bus_done = 1; bus_q = 32'h7777_7777;
    tick();
    bus_done = 0;
    tick();
    check_eq("stray_if_ack", 32'(if_ack), 32'h0);
    check_eq("stray_dm_ack", 32'(dm_ack), 32'h0);
    dm_req = 1; dm_we = 1; dm_addr = AW'(32'h444); dm_wdata = 32'hCAFE_0001;
    tick();
    dm_addr = AW'(32'h555); dm_we = 0; dm_wdata = 32'h0;
    tick();
    check_eq("late_addr", 32'(bus_addr), 32'h444);
    check_eq("late_we",   32'(bus_we),   32'h1);
    bus_done = 1; bus_q = 32'h1111_2222;
    tick();
    check_eq("late_ack", 32'(dm_ack), 32'h1);
    dm_req = 0; bus_done = 0;
    tick();

    // Randomized traffic with random bus latency, stray dones and occasional resets.
    resp_cnt = -1;
    for (int i = 0; i < 3000; i++) begin
      if (if_ack) begin
        if_req = 1'($urandom_range(0, 1));
        if_addr = AW'($urandom());
      end else if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = AW'($urandom());
      end else if ($urandom_range(0, 7) == 0) begin
        if_addr = AW'($urandom());
      end
      if (dm_ack) begin
        dm_req = 1'($urandom_range(0, 1));
        dm_we = 1'($urandom_range(0, 1)); dm_addr = AW'($urandom()); dm_wdata = $urandom();
      end else if (!dm_req && $urandom_range(0, 3) == 0) begin
        dm_req = 1;
        dm_we = 1'($urandom_range(0, 1)); dm_addr = AW'($urandom()); dm_wdata = $urandom();
      end else if ($urandom_range(0, 7) == 0) begin
        dm_we = 1'($urandom_range(0, 1)); dm_addr = AW'($urandom()); dm_wdata = $urandom();
      end
      bus_done = 0;
      if (bus_start) resp_cnt = $urandom_range(0, 3);
      if (resp_cnt == 0) begin
        bus_done = 1; bus_q = $urandom(); resp_cnt = -1;
      end else if (resp_cnt > 0) begin
        resp_cnt--;
      end else if ($urandom_range(0, 9) == 0) begin
        bus_done = 1; bus_q = $urandom();
      end
      if (i % 997 == 500) begin
        do_reset();
        if_req = 0; dm_req = 0; bus_done = 0; resp_cnt = -1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
